// File: rtl/vga_monitor.sv
// vga_monitor: locks to a 640x480 VGA hsync/vsync/color stream, rebuilds pixel coordinates and flags sync/blanking errors.
// Optional feature macro VGA_MON_CHECKSUM_EN: enables the per-frame visible-color checksum on frame_sum (tied to 0 otherwise).
module vga_monitor #(
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525,
    parameter int ERR_W        = 16
) (
    input  logic             pll,
    input  logic             nrst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [2:0]       color,
    output logic [9:0]       x_pos,
    output logic [9:0]       y_pos,
    output logic [2:0]       pix_color,
    output logic             pixel_valid,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err,
    output logic             blank_err,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      frame_sum
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        H_LOCK = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE   = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic       hs_p0, vs_p0, hs_prev_p0, vs_prev_p0;
    logic [2:0] color_p0;
    state_t     state, state_nxt;
    logic [9:0] x_inc, y_inc, x_nxt, y_nxt;
    logic       hs_exp, vs_exp, in_blank;
    logic       se_nxt, be_nxt, fd_nxt, pv_nxt;
    logic [ERR_W:0] err_sum;

    // Stage 0: raw inputs, plus the previous sample for edge detection
    always_ff @(posedge pll or negedge nrst) begin
        if (!nrst) begin
            hs_p0      <= 1'b0;
            vs_p0      <= 1'b0;
            hs_prev_p0 <= 1'b0;
            vs_prev_p0 <= 1'b0;
            color_p0   <= 3'd0;
        end else begin
            hs_prev_p0 <= hs_p0;
            vs_prev_p0 <= vs_p0;
            hs_p0      <= hsync;
            vs_p0      <= vsync;
            color_p0   <= color;
        end
    end

    always_ff @(posedge pll or negedge nrst) begin
        if (!nrst) state <= SEARCH;
        else       state <= state_nxt;
    end

    always_comb begin
        x_inc     = (x_pos == H_LAST) ? 10'd0 : x_pos + 10'd1;
        y_inc     = (x_inc != 10'd0) ? y_pos : ((y_pos == V_LAST) ? 10'd0 : y_pos + 10'd1);
        hs_exp    = (x_inc >= H_SS) && (x_inc < H_SE);
        vs_exp    = (y_inc >= V_SS) && (y_inc < V_SE);
        in_blank  = (x_inc >= H_VIS) || (y_inc >= V_VIS);
        state_nxt = state;
        x_nxt     = 10'd0;
        y_nxt     = 10'd0;
        se_nxt    = 1'b0;
        be_nxt    = 1'b0;
        fd_nxt    = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_p0 && !hs_prev_p0) begin
                    state_nxt = H_LOCK;
                    x_nxt     = H_SS;
                end
            end
            H_LOCK: begin
                // A broken hsync cadence before vertical lock just restarts the search silently
                if (hs_p0 != hs_exp) begin
                    state_nxt = SEARCH;
                end else begin
                    x_nxt = x_inc;
                    if (vs_p0 && !vs_prev_p0 && (x_inc == 10'd0)) begin
                        state_nxt = LOCKED;
                        y_nxt     = V_SS;
                    end
                end
            end
            LOCKED: begin
                be_nxt = (color_p0 != 3'd0) && in_blank;
                if ((hs_p0 != hs_exp) || (vs_p0 != vs_exp)) begin
                    se_nxt    = 1'b1;
                    state_nxt = SEARCH;
                end else begin
                    x_nxt  = x_inc;
                    y_nxt  = y_inc;
                    fd_nxt = (x_inc == H_LAST) && (y_inc == V_LAST);
                end
            end
            default: state_nxt = SEARCH;
        endcase
        pv_nxt = (state_nxt == LOCKED) && (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    // Stage 1: per-sample results, aligned with pix_color
    always_ff @(posedge pll or negedge nrst) begin
        if (!nrst) begin
            x_pos       <= 10'd0;
            y_pos       <= 10'd0;
            pix_color   <= 3'd0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            blank_err   <= 1'b0;
        end else begin
            x_pos       <= x_nxt;
            y_pos       <= y_nxt;
            pix_color   <= color_p0;
            pixel_valid <= pv_nxt;
            frame_done  <= fd_nxt;
            sync_err    <= se_nxt;
            blank_err   <= be_nxt;
        end
    end

    assign locked = (state == LOCKED);

    // Stage 2: saturating error counter trails the pulses by one edge
    always_comb begin
        err_sum = {1'b0, err_count} + {{ERR_W{1'b0}}, sync_err} + {{ERR_W{1'b0}}, blank_err};
    end

    always_ff @(posedge pll or negedge nrst) begin
        if (!nrst)             err_count <= '0;
        else if (err_sum[ERR_W]) err_count <= '1;
        else                   err_count <= err_sum[ERR_W-1:0];
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] acc, acc_sum;

    always_comb begin
        acc_sum = acc + (pv_nxt ? {13'd0, color_p0} : 16'd0);
    end

    always_ff @(posedge pll or negedge nrst) begin
        if (!nrst) begin
            acc       <= 16'd0;
            frame_sum <= 16'd0;
        end else if (state_nxt != LOCKED) begin
            acc <= 16'd0;
        end else if (fd_nxt) begin
            frame_sum <= acc_sum;
            acc       <= 16'd0;
        end else begin
            acc <= acc_sum;
        end
    end
`else
    assign frame_sum = 16'h0000;
`endif

endmodule
